jk_mod_counter: RTL and testbench
=================================

# jk_mod_counter

Synchronous modulo-N up/down counter built from per-bit JK storage cells, clocked on the falling edge like the flip-flop stages it sits beside. Each bit's J/K excitation is computed from the current count, direction, enable and load, so a bit can hold, clear, set or toggle. It consumes the JK flip-flop primitive directly as its state element. Its terminal-count output cascades into the enable of a following counter stage.

## Interface
- WIDTH, 4: count register width in bits; must satisfy 2**WIDTH >= MODULUS.
- MODULUS, 10: count range 0..MODULUS-1; must be >= 2 (elaboration error otherwise).
- Clk_In  input  1  clock; all state changes on falling edge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Enable_In  input  1  count enable, sampled on falling edge.
- Up_Down_In  input  1  1 = count up, 0 = count down.
- Load_In  input  1  synchronous load request.
- Load_Value_In  input  WIDTH  value loaded when Load_In = 1.
- Count_Out  output  WIDTH  current count.
- Terminal_Count_Out  output  1  combinational; count at terminal value for current direction.
- Wrap_Out  output  1  registered one-cycle pulse after a wrap.

## Operation
- Reset: Count_Out = 0, Wrap_Out = 0, asynchronously and immediately, including mid-count. Terminal_Count_Out is then 1 if Up_Down_In = 0, else 0.
- Priority on each falling edge: Load_In, then Enable_In, then hold.
- Load: Count_Out <= Load_Value_In if Load_Value_In < MODULUS, else 0. Wrap_Out <= 0. Enable_In is ignored that cycle.
- Count up (Enable_In = 1, Up_Down_In = 1): if Count_Out = MODULUS-1, next count is 0 and Wrap_Out <= 1; else Count_Out + 1.
- Count down (Enable_In = 1, Up_Down_In = 0): if Count_Out = 0, next count is MODULUS-1 and Wrap_Out <= 1; else Count_Out - 1.
- Hold (Enable_In = 0, Load_In = 0): count unchanged, Wrap_Out <= 0.
- Terminal_Count_Out = (Up_Down_In & Count_Out == MODULUS-1) | (~Up_Down_In & Count_Out == 0). It is independent of Enable_In so stages cascade as next.Enable_In = Enable_In & Terminal_Count_Out.
- Excitation per bit, from next count N and current count C:
  - {J,K} = 2'b11 (toggle) where N != C.
  - 2'b00 (hold) otherwise.
  - Load and wrap may instead drive 2'b10 (set) / 2'b01 (clear) directly from the target bit; the result must be identical.
- Direction change takes effect on the next falling edge; no state beyond the count is retained.
- Count_Out never leaves 0..MODULUS-1 after reset.

## Timing
- Latency: one falling edge from sampled inputs to updated Count_Out and Wrap_Out.
- Rising edges of Clk_In have no effect.
- Wrap_Out is high for exactly one clock period (falling edge to falling edge) per wrap; back-to-back wraps (MODULUS = 2, continuous enable) keep it high continuously.
- Terminal_Count_Out follows Count_Out and Up_Down_In combinationally, with no register delay.
- Reset deassertion: first count/load occurs on the first falling edge after Reset_In goes low.

## Structure
- Shared package (jk_counter_pkg):
  - JK code constants JK_HOLD = 2'b00, JK_CLEAR = 2'b01, JK_SET = 2'b10, JK_TOGGLE = 2'b11.
  - Direction constants DIR_DOWN = 0, DIR_UP = 1.
- Sub-module jk_bit_cell: one falling-edge JK storage bit with asynchronous active-high reset to 0 and Q/Qb outputs. Instantiated WIDTH times via generate.
- Top level holds the next-count computation, per-bit J/K excitation, terminal-count decode and the Wrap_Out register.

## Test plan
- Reset then count: WIDTH = 4, MODULUS = 10, Up = 1, Enable = 1 for 12 falling edges -> 1..9, 0, 1, 2; Wrap_Out pulses once, the cycle count reads 0; Terminal_Count_Out high only at 9.
- Count down from reset: Up = 0, Enable = 1 -> first edge gives 9 with Wrap_Out = 1; then 8, 7, and so on.
- Load priority: Load_In = 1 with Load_Value_In = 6 and Enable = 1 -> Count_Out = 6, Wrap_Out = 0; Load_Value_In = 12 -> Count_Out = 0.
- Hold: Enable = 0 at count 5 for 4 edges -> stays 5, Wrap_Out = 0. Flip Up_Down_In at count 0 -> Terminal_Count_Out toggles with no edge.
- Async reset mid-operation: Reset_In pulsed between edges at count 7 -> Count_Out = 0 and Wrap_Out = 0 immediately; counting resumes from 0 on the next falling edge.
- Cascade: two instances, second enabled by Enable & first's Terminal_Count_Out, Up = 1 -> 100 edges give count pair 00..99 then 00.

Source files
------------

// File: rtl/jk_counter_pkg.sv
// Shared constants for the JK-cell modulo counter.
// JK excitation codes, direction codes, excitation helper.
package jk_counter_pkg;

  typedef logic [1:0] jk_t;

  localparam jk_t JK_HOLD   = 2'b00;
  localparam jk_t JK_CLEAR  = 2'b01;
  localparam jk_t JK_SET    = 2'b10;
  localparam jk_t JK_TOGGLE = 2'b11;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Toggle exactly the bits that must change.
  function automatic jk_t jk_excite(
    input logic cur,
    input logic nxt
  );
    return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_bit_cell.sv
// Single falling-edge JK storage bit.
// Async active-high reset to 0, Q and Qb outputs.
module jk_bit_cell
  import jk_counter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o,
  output logic qb_o
);

  logic q_q;
  logic q_d;

  // JK characteristic equation
  always_comb begin
    q_d = q_q;
    unique case ({j_i, k_i})
      JK_HOLD:   q_d = q_q;
      JK_CLEAR:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // State bit, falling edge, async reset
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o  = q_q;
  assign qb_o = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter on per-bit JK cells.
// Falling-edge; terminal count cascades into next stage.
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic             Up_Down_In,
  input  logic             Load_In,
  input  logic [WIDTH-1:0] Load_Value_In,
  output logic [WIDTH-1:0] Count_Out,
  output logic             Terminal_Count_Out,
  output logic             Wrap_Out
);

  if (MODULUS < 2) begin : g_bad_mod
    $error("jk_mod_counter: MODULUS must be >= 2");
  end

  if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
    $error("jk_mod_counter: WIDTH too small");
  end

  localparam logic [WIDTH-1:0] CNT_MAX =
    WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_qb;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic             go_up;
  logic             go_dn;

  assign at_max  = (count_q == CNT_MAX);
  assign at_zero = &count_qb;
  assign load_ok = 32'(Load_Value_In) < 32'(MODULUS);
  assign go_up   = !Load_In && Enable_In &&
                   (Up_Down_In == DIR_UP);
  assign go_dn   = !Load_In && Enable_In &&
                   (Up_Down_In == DIR_DOWN);

  // Next count and wrap flag: load > count > hold
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (1'b1)
      Load_In: begin
        count_d = load_ok ? Load_Value_In : '0;
      end
      go_up: begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      go_dn: begin
        if (at_zero) begin
          count_d = CNT_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_t jk;
    assign jk = jk_excite(count_q[i], count_d[i]);
    jk_bit_cell u_cell (
      .clk_i (Clk_In),
      .rst_i (Reset_In),
      .j_i   (jk[1]),
      .k_i   (jk[0]),
      .q_o   (count_q[i]),
      .qb_o  (count_qb[i])
    );
  end

  // Wrap pulse register, falling edge, async reset
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) wrap_q <= 1'b0;
    else          wrap_q <= wrap_d;
  end

  assign Count_Out          = count_q;
  assign Wrap_Out           = wrap_q;
  assign Terminal_Count_Out =
    (Up_Down_In == DIR_UP) ? at_max : at_zero;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter.
// Main DUT plus a two-stage decade cascade.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] lv;
  logic [3:0] cnt;
  logic       tc;
  logic       wrap;

  logic       cen;
  logic [3:0] lo_cnt;
  logic [3:0] hi_cnt;
  logic       lo_tc;
  logic       hi_tc;
  logic       lo_wrap;
  logic       hi_wrap;
  logic       hi_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk_In             (clk),
    .Reset_In           (rst),
    .Enable_In          (en),
    .Up_Down_In         (up),
    .Load_In            (ld),
    .Load_Value_In      (lv),
    .Count_Out          (cnt),
    .Terminal_Count_Out (tc),
    .Wrap_Out           (wrap)
  );

  assign hi_en = cen & lo_tc;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .Clk_In             (clk),
    .Reset_In           (rst),
    .Enable_In          (cen),
    .Up_Down_In         (1'b1),
    .Load_In            (1'b0),
    .Load_Value_In      (4'd0),
    .Count_Out          (lo_cnt),
    .Terminal_Count_Out (lo_tc),
    .Wrap_Out           (lo_wrap)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .Clk_In             (clk),
    .Reset_In           (rst),
    .Enable_In          (hi_en),
    .Up_Down_In         (1'b1),
    .Load_In            (1'b0),
    .Load_Value_In      (4'd0),
    .Count_Out          (hi_cnt),
    .Terminal_Count_Out (hi_tc),
    .Wrap_Out           (hi_wrap)
  );

  task automatic edge1;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; up = 1'b0;
    ld = 1'b0; lv = 4'd0; cen = 1'b0;
    #3;
    n_cmp++;
    if (cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_cnt got %0d want 0", cnt);
    end
    n_cmp++;
    if (wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wrap got %b want 0", wrap);
    end
    n_cmp++;
    if (tc !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_tc_dn got %b want 1", tc);
    end
    up = 1'b1;
    #1;
    n_cmp++;
    if (tc !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_tc_up got %b want 0", tc);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_count_up;
    int e;
    do_reset();
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge1();
      e = (i + 1) % 10;
      n_cmp++;
      if (cnt !== 4'(e)) begin
        n_bad++;
        $display("FAIL up_cnt[%0d] got %0d want %0d",
                 i, cnt, e);
      end
      n_cmp++;
      if (wrap !== (e == 0)) begin
        n_bad++;
        $display("FAIL up_wrap[%0d] got %b want %b",
                 i, wrap, (e == 0));
      end
      n_cmp++;
      if (tc !== (e == 9)) begin
        n_bad++;
        $display("FAIL up_tc[%0d] got %b want %b",
                 i, tc, (e == 9));
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (cnt !== 4'(e)) begin
        n_bad++;
        $display("FAIL up_rise[%0d] got %0d want %0d",
                 i, cnt, e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down;
    int e;
    do_reset();
    up = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge1();
      e = (19 - i) % 10;
      n_cmp++;
      if (cnt !== 4'(e)) begin
        n_bad++;
        $display("FAIL dn_cnt[%0d] got %0d want %0d",
                 i, cnt, e);
      end
      n_cmp++;
      if (wrap !== (i == 0 || i == 10)) begin
        n_bad++;
        $display("FAIL dn_wrap[%0d] got %b want %b",
                 i, wrap, (i == 0 || i == 10));
      end
      n_cmp++;
      if (tc !== (e == 0)) begin
        n_bad++;
        $display("FAIL dn_tc[%0d] got %b want %b",
                 i, tc, (e == 0));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load;
    logic [3:0] vals [5];
    logic [3:0] exps [5];
    vals = '{4'd6, 4'd12, 4'd9, 4'd3, 4'd15};
    exps = '{4'd6, 4'd0,  4'd9, 4'd3, 4'd0};
    en = 1'b1; up = 1'b1; ld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lv = vals[i];
      edge1();
      n_cmp++;
      if (cnt !== exps[i]) begin
        n_bad++;
        $display("FAIL load_cnt[%0d] got %0d want %0d",
                 i, cnt, exps[i]);
      end
      n_cmp++;
      if (wrap !== 1'b0) begin
        n_bad++;
        $display("FAIL load_wrap[%0d] got %b want 0",
                 i, wrap);
      end
    end
    ld = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold;
    ld = 1'b1; lv = 4'd5; en = 1'b0; up = 1'b1;
    edge1();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = i[0];
      edge1();
      n_cmp++;
      if (cnt !== 4'd5) begin
        n_bad++;
        $display("FAIL hold_cnt[%0d] got %0d want 5",
                 i, cnt);
      end
      n_cmp++;
      if (wrap !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_wrap[%0d] got %b want 0",
                 i, wrap);
      end
    end
    ld = 1'b1; lv = 4'd0;
    edge1();
    ld = 1'b0; up = 1'b0;
    #1;
    n_cmp++;
    if (tc !== 1'b1) begin
      n_bad++;
      $display("FAIL flip_tc_dn got %b want 1", tc);
    end
    up = 1'b1;
    #1;
    n_cmp++;
    if (tc !== 1'b0) begin
      n_bad++;
      $display("FAIL flip_tc_up got %b want 0", tc);
    end
  endtask

  task automatic test_async_reset;
    en = 1'b1; up = 1'b1; ld = 1'b1; lv = 4'd6;
    edge1();
    ld = 1'b0;
    edge1();
    n_cmp++;
    if (cnt !== 4'd7) begin
      n_bad++;
      $display("FAIL ar_pre got %0d want 7", cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cnt !== 4'd0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_mid got %0d/%b want 0/0",
               cnt, wrap);
    end
    rst = 1'b0;
    edge1();
    n_cmp++;
    if (cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL ar_resume got %0d want 1", cnt);
    end
    ld = 1'b1; lv = 4'd9;
    edge1();
    ld = 1'b0;
    edge1();
    n_cmp++;
    if (cnt !== 4'd0 || wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_wrap got %0d/%b want 0/1",
               cnt, wrap);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_wrap_clr got %b want 0", wrap);
    end
    rst = 1'b0;
    edge1();
    n_cmp++;
    if (cnt !== 4'd1 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_resume2 got %0d/%b want 1/0",
               cnt, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic       dirs [4];
    logic [3:0] ecnt [4];
    logic       ewr  [4];
    dirs = '{1'b1, 1'b0, 1'b1, 1'b1};
    ecnt = '{4'd0, 4'd9, 4'd0, 4'd0};
    ewr  = '{1'b1, 1'b1, 1'b1, 1'b0};
    ld = 1'b1; lv = 4'd9;
    edge1();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = dirs[i];
      en = (i < 3);
      edge1();
      n_cmp++;
      if (cnt !== ecnt[i] || wrap !== ewr[i]) begin
        n_bad++;
        $display("FAIL b2b[%0d] got %0d/%b want %0d/%b",
                 i, cnt, wrap, ecnt[i], ewr[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_cascade;
    int n;
    int lo;
    int hi;
    en = 1'b0; cen = 1'b0;
    do_reset();
    n_cmp++;
    if (lo_cnt !== 4'd0 || hi_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL casc_init got %0d%0d want 00",
               hi_cnt, lo_cnt);
    end
    cen = 1'b1;
    for (int i = 0; i < 100; i++) begin
      edge1();
      n  = (i + 1) % 100;
      lo = n % 10;
      hi = n / 10;
      n_cmp++;
      if (lo_cnt !== 4'(lo) || hi_cnt !== 4'(hi)) begin
        n_bad++;
        $display("FAIL casc[%0d] got %0d%0d want %0d%0d",
                 i, hi_cnt, lo_cnt, hi, lo);
      end
      n_cmp++;
      if (lo_wrap !== (lo == 0) ||
          hi_wrap !== (n == 0)) begin
        n_bad++;
        $display("FAIL casc_wrap[%0d] got %b%b want %b%b",
                 i, hi_wrap, lo_wrap, (n == 0), (lo == 0));
      end
      n_cmp++;
      if (hi_tc !== (hi == 9)) begin
        n_bad++;
        $display("FAIL casc_tc[%0d] got %b want %b",
                 i, hi_tc, (hi == 9));
      end
    end
    cen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
